// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the mult/div sequencing controller: op codes, unit
// function codes, FSM states and the op-to-function mapping.
package muldiv_ctrl_pkg;

  localparam int kOpWidth = 4;
  localparam int FUNCT_W  = 6;

  typedef enum logic [kOpWidth-1:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_MUL   = 4'd3,
    OP_DIV   = 4'd4,
    OP_DIVU  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } op_e;

  typedef logic [FUNCT_W-1:0] funct_t;

  localparam funct_t FUNCT_NONE  = 6'h00;
  localparam funct_t FUNCT_MULT  = 6'h18;
  localparam funct_t FUNCT_MULTU = 6'h19;
  localparam funct_t FUNCT_DIV   = 6'h1A;
  localparam funct_t FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_ACCUM = 2'd2,
    S_WB    = 2'd3
  } state_e;

  function automatic funct_t op2funct(input op_e op);
    funct_t f;
    f = FUNCT_NONE;
    case (op)
      OP_MULT, OP_MUL, OP_MADD, OP_MSUB: f = FUNCT_MULT;
      OP_MULTU, OP_MADDU, OP_MSUBU:      f = FUNCT_MULTU;
      OP_DIV:                            f = FUNCT_DIV;
      OP_DIVU:                           f = FUNCT_DIVU;
      default:                           f = FUNCT_NONE;
    endcase
    return f;
  endfunction

  function automatic logic is_accum(input op_e op);
    return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_sub(input op_e op);
    return op inside {OP_MSUB, OP_MSUBU};
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage and multiply/divide-unit signals seen by the controller.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic         flush;
  logic         req_valid;
  op_e          req_op;
  logic [31:0]  req_op1;
  logic [31:0]  req_op2;
  logic         mt_hi_we;
  logic         mt_lo_we;
  logic [31:0]  mt_data;
  logic         stall_req;
  funct_t       md_funct;
  logic [31:0]  md_op1;
  logic [31:0]  md_op2;
  logic         md_done;
  logic [63:0]  md_result;
  logic [31:0]  hi_o;
  logic [31:0]  lo_o;
  logic         mul_valid;
  logic [31:0]  mul_result;

  modport master (
    output flush, req_valid, req_op, req_op1, req_op2,
           mt_hi_we, mt_lo_we, mt_data, md_done, md_result,
    input  stall_req, md_funct, md_op1, md_op2, hi_o, lo_o, mul_valid, mul_result
  );

  modport slave (
    input  flush, req_valid, req_op, req_op1, req_op2,
           mt_hi_we, mt_lo_we, mt_data, md_done, md_result,
    output stall_req, md_funct, md_op1, md_op2, hi_o, lo_o, mul_valid, mul_result
  );
endinterface

// File: rtl/muldiv_ctrl_hilo_reg.sv
// Architectural HI/LO registers; the commit port wins over MTHI/MTLO.
module hilo_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mt_hi_we,
  input  logic        i_mt_lo_we,
  input  logic [31:0] i_mt_data,
  input  logic        i_cm_we,
  input  logic [63:0] i_cm_data,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);
  logic [31:0] r_hi, r_lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_cm_we) begin
      r_hi <= i_cm_data[63:32];
      r_lo <= i_cm_data[31:0];
    end else begin
      if (i_mt_hi_we) r_hi <= i_mt_data;
      if (i_mt_lo_we) r_lo <= i_mt_data;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;
endmodule

// File: rtl/muldiv_ctrl.sv
// Sequences one HI/LO-class op through the shared mult/div unit, stalling EX,
// accumulating for MADD/MSUB and committing the result to HI/LO.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);
  state_e      r_state, w_state_n;
  op_e         r_op;
  logic [31:0] r_op1, r_op2;
  logic [63:0] r_prod;
  funct_t      r_md_funct;
  logic        r_first, r_mul_valid;
  logic        w_req, w_accept, w_done, w_cm_we, w_mt_ok;
  op_e         w_fn_op;

  assign w_req    = bus.req_valid && (bus.req_op != OP_NONE);
  assign w_accept = (r_state == S_IDLE) && w_req && !bus.flush;
  // The unit may still present a stale done when BUSY is entered.
  assign w_done   = (r_state == S_BUSY) && !r_first && bus.md_done;

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_n = S_BUSY;
      S_BUSY:  if (w_done) w_state_n = is_accum(r_op) ? S_ACCUM : S_WB;
      S_ACCUM: w_state_n = S_WB;
      S_WB:    w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
    if (bus.flush) w_state_n = S_IDLE;
  end

  assign w_fn_op = (r_state == S_IDLE) ? bus.req_op : r_op;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_NONE;
      r_op1       <= '0;
      r_op2       <= '0;
      r_prod      <= '0;
      r_md_funct  <= FUNCT_NONE;
      r_first     <= 1'b0;
      r_mul_valid <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_first     <= w_accept;
      r_md_funct  <= (w_state_n == S_BUSY) ? op2funct(w_fn_op) : FUNCT_NONE;
      r_mul_valid <= (w_state_n == S_WB) && (r_op == OP_MUL);
      if (w_accept) begin
        r_op  <= bus.req_op;
        r_op1 <= bus.req_op1;
        r_op2 <= bus.req_op2;
      end
      // The product register doubles as the accumulator result for MADD/MSUB.
      if (w_done)
        r_prod <= bus.md_result;
      else if (r_state == S_ACCUM)
        r_prod <= is_sub(r_op) ? ({bus.hi_o, bus.lo_o} - r_prod)
                               : ({bus.hi_o, bus.lo_o} + r_prod);
    end
  end

  assign w_cm_we = (r_state == S_WB) && !bus.flush && (r_op != OP_MUL);
  assign w_mt_ok = (r_state == S_IDLE);

  hilo_reg u_hilo (
    .clk        (clk),
    .rst        (rst),
    .i_mt_hi_we (bus.mt_hi_we && w_mt_ok),
    .i_mt_lo_we (bus.mt_lo_we && w_mt_ok),
    .i_mt_data  (bus.mt_data),
    .i_cm_we    (w_cm_we),
    .i_cm_data  (r_prod),
    .o_hi       (bus.hi_o),
    .o_lo       (bus.lo_o)
  );

  assign bus.stall_req  = (r_state == S_IDLE) ? w_req : (r_state != S_WB);
  assign bus.md_funct   = r_md_funct;
  assign bus.md_op1     = r_op1;
  assign bus.md_op2     = r_op2;
  assign bus.mul_valid  = r_mul_valid;
  assign bus.mul_result = r_prod[31:0];
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a latency-programmable mult/div unit model.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   lat = 1;
  int   cnt = 0;
  logic stale = 1'b0;
  logic [63:0] md_res;

  always #5 clk = ~clk;

  muldiv_ctrl_if bus ();

  muldiv_ctrl dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  // Unit model: done after lat cycles of a held function code.
  always @(posedge clk) cnt <= (bus.md_funct != FUNCT_NONE) ? cnt + 1 : 0;

  always_comb begin
    logic signed [63:0] sa, sb;
    sa = {{32{bus.md_op1[31]}}, bus.md_op1};
    sb = {{32{bus.md_op2[31]}}, bus.md_op2};
    md_res = '0;
    case (bus.md_funct)
      FUNCT_MULT:  md_res = sa * sb;
      FUNCT_MULTU: md_res = {32'd0, bus.md_op1} * {32'd0, bus.md_op2};
      FUNCT_DIV:   md_res = (bus.md_op2 == 0) ? {bus.md_op1, 32'hFFFF_FFFF} :
                            {32'($signed(bus.md_op1) % $signed(bus.md_op2)),
                             32'($signed(bus.md_op1) / $signed(bus.md_op2))};
      FUNCT_DIVU:  md_res = (bus.md_op2 == 0) ? {bus.md_op1, 32'hFFFF_FFFF} :
                            {bus.md_op1 % bus.md_op2, bus.md_op1 / bus.md_op2};
      default:     md_res = '0;
    endcase
  end

  assign bus.md_result = md_res;
  assign bus.md_done   = (bus.md_funct != FUNCT_NONE) && ((cnt == lat) || (stale && cnt == 0));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue at the current negedge; returns at the negedge of the WB cycle.
  task automatic do_op(input op_e op, input logic [31:0] a, input logic [31:0] b, input int l,
                       output int n_st, output int n_fn, output int n_mv, output logic [31:0] mres);
    lat = l;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_op1   = a;
    bus.req_op2   = b;
    n_st = 0; n_fn = 0; n_mv = 0;
    #1;
    while (bus.stall_req && n_st < 100) begin
      n_st++;
      if (bus.md_funct == op2funct(op)) n_fn++;
      @(negedge clk); #1;
      if (bus.mul_valid) n_mv++;
    end
    if (n_st >= 100) chk("stall_timeout", 64'(n_st), 64'd0);
    mres = bus.mul_result;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_NONE;
  endtask

  task automatic hilo(input string tag, input logic [63:0] exp);
    chk(tag, {bus.hi_o, bus.lo_o}, exp);
  endtask

  initial begin
    int st, fn, mv;
    logic [31:0] mr;
    bus.flush = 1'b0; bus.req_valid = 1'b0; bus.req_op = OP_NONE;
    bus.req_op1 = '0; bus.req_op2 = '0;
    bus.mt_hi_we = 1'b0; bus.mt_lo_we = 1'b0; bus.mt_data = '0;

    #12 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_stall", 64'(bus.stall_req), 64'd0);
    chk("rst_funct", 64'(bus.md_funct), 64'd0);
    hilo("rst_hilo", 64'd0);

    // MULT -2 x 3, latency 1
    do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1, st, fn, mv, mr);
    chk("mult_stall", 64'(st), 64'd3);
    chk("mult_wb_funct", 64'(bus.md_funct), 64'd0);
    @(negedge clk);
    hilo("mult_hilo", 64'hFFFF_FFFF_FFFF_FFFA);

    // DIVU 100/7 issued in the IDLE cycle right after WB
    do_op(OP_DIVU, 32'd100, 32'd7, 17, st, fn, mv, mr);
    chk("divu_stall", 64'(st), 64'd19);
    chk("divu_funct_cyc", 64'(fn), 64'd18);
    chk("divu_mv", 64'(mv), 64'd0);
    @(negedge clk);
    hilo("divu_hilo", {32'd2, 32'd14});

    // Divide by zero: unit result committed as-is
    do_op(OP_DIVU, 32'd5, 32'd0, 17, st, fn, mv, mr);
    @(negedge clk);
    hilo("div0_hilo", {32'd5, 32'hFFFF_FFFF});

    bus.mt_hi_we = 1'b1; bus.mt_data = 32'd0;
    @(negedge clk);
    bus.mt_hi_we = 1'b0; bus.mt_lo_we = 1'b1; bus.mt_data = 32'd10;
    @(negedge clk);
    bus.mt_lo_we = 1'b0;
    hilo("mt_hilo", {32'd0, 32'd10});

    do_op(OP_MADD, 32'd5, 32'hFFFF_FFFD, 1, st, fn, mv, mr);
    chk("madd_stall", 64'(st), 64'd4);
    @(negedge clk);
    hilo("madd_hilo", 64'hFFFF_FFFF_FFFF_FFFB);

    do_op(OP_MSUBU, 32'd1, 32'd1, 1, st, fn, mv, mr);
    @(negedge clk);
    hilo("msubu_hilo", 64'hFFFF_FFFF_FFFF_FFFA);

    do_op(OP_MUL, 32'd7, 32'd6, 1, st, fn, mv, mr);
    chk("mul_mv", 64'(mv), 64'd1);
    chk("mul_res", 64'(mr), 64'd42);
    @(negedge clk); #1;
    chk("mul_mv_after", 64'(bus.mul_valid), 64'd0);
    hilo("mul_hilo", 64'hFFFF_FFFF_FFFF_FFFA);

    // Flush in BUSY cycle 5 of a DIV; an MTHI in BUSY must be ignored
    lat = 17;
    bus.req_valid = 1'b1; bus.req_op = OP_DIV; bus.req_op1 = 32'd50; bus.req_op2 = 32'd3;
    repeat (5) @(negedge clk);
    bus.flush = 1'b1; bus.req_valid = 1'b0; bus.req_op = OP_NONE;
    bus.mt_hi_we = 1'b1; bus.mt_data = 32'hDEAD;
    @(negedge clk);
    bus.flush = 1'b0; bus.mt_hi_we = 1'b0;
    #1;
    chk("flush_funct", 64'(bus.md_funct), 64'd0);
    chk("flush_stall", 64'(bus.stall_req), 64'd0);
    hilo("flush_hilo", 64'hFFFF_FFFF_FFFF_FFFA);
    @(negedge clk);

    do_op(OP_MULT, 32'd2, 32'd3, 1, st, fn, mv, mr);
    chk("post_flush_stall", 64'(st), 64'd3);
    @(negedge clk);
    hilo("post_flush_hilo", {32'd0, 32'd6});

    // Flush during WB suppresses the commit
    do_op(OP_MULT, 32'd4, 32'd5, 1, st, fn, mv, mr);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    hilo("wb_flush_hilo", {32'd0, 32'd6});

    // Async reset mid-DIV
    lat = 17;
    bus.req_valid = 1'b1; bus.req_op = OP_DIVU; bus.req_op1 = 32'd100; bus.req_op2 = 32'd7;
    repeat (3) @(negedge clk);
    #2;
    bus.req_valid = 1'b0; bus.req_op = OP_NONE;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", 64'(bus.stall_req), 64'd0);
    chk("arst_funct", 64'(bus.md_funct), 64'd0);
    chk("arst_ops", {bus.md_op1, bus.md_op2}, 64'd0);
    hilo("arst_hilo", 64'd0);
    chk("arst_mul", {31'd0, bus.mul_valid, bus.mul_result}, 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Stale done in the first BUSY cycle must be ignored
    stale = 1'b1;
    do_op(OP_MULTU, 32'd3, 32'd4, 3, st, fn, mv, mr);
    stale = 1'b0;
    chk("stale_stall", 64'(st), 64'd5);
    @(negedge clk);
    hilo("stale_hilo", {32'd0, 32'd12});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
